// File: rtl/factor_round_ctrl_pkg.sv
// Shared types and constants for the factorization game round controller.
package factor_pkg;

  localparam int ANS_W  = 24;  // player answer / expected-answer width
  localparam int WORD_W = 36;  // problem word width; [23:0] holds the expected answer

  // Checker verdict encodings
  localparam logic [1:0] RES_IDLE = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b01;
  localparam logic [1:0] RES_NG   = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_ANS = 3'd2,
    CHECK    = 3'd3,
    SHOW     = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Bits needed to hold a counter value of max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/factor_round_ctrl_if.sv
// Bus bundle between the round controller and its environment
// (entry logic, problem ROM, answer checker, display).
interface factor_round_ctrl_if import factor_pkg::*; #(
  parameter int ADDR_W = 3
) ();

  logic              start;      // 1-clk pulse: begin session
  logic              submit;     // 1-clk pulse: answer_in valid
  logic [ANS_W-1:0]  answer_in;  // player answer
  logic [ADDR_W-1:0] rom_addr;   // problem ROM address
  logic [WORD_W-1:0] rom_data;   // problem word, one clock after rom_addr
  logic [WORD_W-1:0] num_array;  // registered problem word to checker
  logic [ANS_W-1:0]  check_in;   // answer to checker; 0 = checker idle
  logic [1:0]        result;     // checker verdict
  logic [1:0]        led;        // displayed verdict
  logic [ADDR_W:0]   score;      // correct answers this session
  logic [ADDR_W-1:0] q_idx;      // current problem index
  logic              busy;       // session in progress
  logic              done;       // session finished

  // Controller side: drives ROM address, checker inputs and status
  modport master (
    input  start, submit, answer_in, rom_data, result,
    output rom_addr, num_array, check_in, led, score, q_idx, busy, done
  );

  // Environment side: entry logic, ROM and checker
  modport slave (
    output start, submit, answer_in, rom_data, result,
    input  rom_addr, num_array, check_in, led, score, q_idx, busy, done
  );

endinterface

// File: rtl/factor_round_ctrl_timer.sv
// round_timer: loadable down-counter with a zero flag. Loading takes
// priority over decrementing; the count parks at zero.
module round_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load, decrement toward zero, or hold
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/factor_round_ctrl.sv
// factor_round_ctrl: sequences one game session of NUM_Q problems.
// Fetches each problem word from a synchronous ROM, waits for a non-zero
// answer, drives the checker for CHECK_LAT+1 clocks, latches the verdict
// onto the LEDs, shows it for DISP_CYC clocks and keeps score.
// Optional feature: define FACTOR_TIMEOUT_EN to give each answer a
// TIMEOUT_CYC-clock limit; expiry scores the problem as wrong.
module factor_round_ctrl import factor_pkg::*; #(
  parameter int NUM_Q       = 8,
  parameter int ADDR_W      = 3,
  parameter int CHECK_LAT   = 2,
  parameter int DISP_CYC    = 50,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  factor_round_ctrl_if.master  bus
);

  // A wait of N clocks loads N-1 on entry and leaves when the count hits zero.
`ifdef FACTOR_TIMEOUT_EN
  localparam int TMR_MAX = max3(CHECK_LAT, DISP_CYC - 1, TIMEOUT_CYC - 1);
`else
  localparam int TMR_MAX = max3(CHECK_LAT, DISP_CYC - 1, 1);
`endif
  localparam int TMR_W = cnt_width(TMR_MAX);

  localparam logic [TMR_W-1:0] LD_FETCH = TMR_W'(1);
  localparam logic [TMR_W-1:0] LD_CHECK = TMR_W'(CHECK_LAT);
  localparam logic [TMR_W-1:0] LD_SHOW  = TMR_W'(DISP_CYC - 1);
`ifdef FACTOR_TIMEOUT_EN
  localparam logic [TMR_W-1:0] LD_WAIT  = TMR_W'(TIMEOUT_CYC - 1);
`endif
  localparam logic [ADDR_W-1:0] LAST_Q    = ADDR_W'(NUM_Q - 1);
  localparam logic [ADDR_W:0]   SCORE_MAX = (ADDR_W + 1)'(NUM_Q);

  state_e state_q, state_d;

  logic [WORD_W-1:0] num_array_q, num_array_d;
  logic [ANS_W-1:0]  check_in_q,  check_in_d;
  logic [1:0]        led_q,       led_d;
  logic [ADDR_W:0]   score_q,     score_d;
  logic [ADDR_W-1:0] q_idx_q,     q_idx_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  logic start_ok;    // start accepted (only from IDLE or DONE)
  logic submit_ok;   // non-zero answer accepted in WAIT_ANS
  logic fetch_end;   // second FETCH clock: ROM word is valid
  logic check_end;   // last CHECK clock: checker verdict is valid
  logic show_end;    // last SHOW clock
`ifdef FACTOR_TIMEOUT_EN
  logic timeout_hit; // answer window expired with no valid submit
`endif

  assign start_ok  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign submit_ok = bus.submit && (state_q == WAIT_ANS) && (bus.answer_in != '0);
  assign fetch_end = (state_q == FETCH) && tmr_zero;
  assign check_end = (state_q == CHECK) && tmr_zero;
  assign show_end  = (state_q == SHOW)  && tmr_zero;
`ifdef FACTOR_TIMEOUT_EN
  // A valid submit on the expiry clock takes precedence
  assign timeout_hit = (state_q == WAIT_ANS) && tmr_zero && !submit_ok;
`endif

  // One shared timer times FETCH, CHECK, SHOW and the answer window
  round_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_ok) state_d = FETCH;
      FETCH:      if (tmr_zero) state_d = WAIT_ANS;
      WAIT_ANS: begin
        if (submit_ok) state_d = CHECK;
`ifdef FACTOR_TIMEOUT_EN
        else if (tmr_zero) state_d = SHOW;
`endif
      end
      CHECK:      if (tmr_zero) state_d = SHOW;
      SHOW:       if (tmr_zero) state_d = (q_idx_q == LAST_Q) ? DONE : FETCH;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state_q != IDLE) && (state_q != DONE);
    bus.done = (state_q == DONE);
  end

  // Timer control: reload on entry to each timed state, otherwise count down
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = (state_q != IDLE) && (state_q != DONE);
    if (state_d != state_q) begin
      unique case (state_d)
        FETCH: begin tmr_load = 1'b1; tmr_val = LD_FETCH; end
        CHECK: begin tmr_load = 1'b1; tmr_val = LD_CHECK; end
        SHOW:  begin tmr_load = 1'b1; tmr_val = LD_SHOW;  end
`ifdef FACTOR_TIMEOUT_EN
        WAIT_ANS: begin tmr_load = 1'b1; tmr_val = LD_WAIT; end
`endif
        default: ;
      endcase
    end
  end

  // Datapath next-state: problem word, checker input, verdict, score, index
  always_comb begin
    num_array_d = num_array_q;
    check_in_d  = check_in_q;
    led_d       = led_q;
    score_d     = score_q;
    q_idx_d     = q_idx_q;

    if (start_ok) begin
      score_d = '0;
      q_idx_d = '0;
      led_d   = RES_IDLE;
    end

    if (fetch_end) num_array_d = bus.rom_data;

    if (submit_ok) check_in_d = bus.answer_in;

    // Only an explicit OK verdict scores; idle (00) and NG both count as wrong
    if (check_end) begin
      led_d = bus.result;
      if ((bus.result == RES_OK) && (score_q != SCORE_MAX)) begin
        score_d = score_q + (ADDR_W + 1)'(1);
      end
    end

`ifdef FACTOR_TIMEOUT_EN
    if (timeout_hit) led_d = RES_NG;
`endif

    if (show_end) begin
      check_in_d = '0;
      if (q_idx_q != LAST_Q) q_idx_d = q_idx_q + ADDR_W'(1);
    end
  end

  // Datapath registers; reset clears check_in at once so an aborted round releases the checker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_array_q <= '0;
      check_in_q  <= '0;
      led_q       <= RES_IDLE;
      score_q     <= '0;
      q_idx_q     <= '0;
    end else begin
      num_array_q <= num_array_d;
      check_in_q  <= check_in_d;
      led_q       <= led_d;
      score_q     <= score_d;
      q_idx_q     <= q_idx_d;
    end
  end

  assign bus.rom_addr  = q_idx_q;
  assign bus.num_array = num_array_q;
  assign bus.check_in  = check_in_q;
  assign bus.led       = led_q;
  assign bus.score     = score_q;
  assign bus.q_idx     = q_idx_q;

endmodule

// File: tb/tb_factor_round_ctrl.sv
// Self-checking bench for factor_round_ctrl: table of answer rounds plus
// hand-written sequences for ignored inputs, restart from DONE, async reset
// mid-CHECK and (with FACTOR_TIMEOUT_EN) the answer timeout.
module tb_factor_round_ctrl;
  import factor_pkg::*;

  localparam int NUM_Q       = 2;
  localparam int ADDR_W      = 1;
  localparam int CHECK_LAT   = 2;
  localparam int DISP_CYC    = 4;
  localparam int TIMEOUT_CYC = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  factor_round_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  factor_round_ctrl #(
    .NUM_Q       (NUM_Q),
    .ADDR_W      (ADDR_W),
    .CHECK_LAT   (CHECK_LAT),
    .DISP_CYC    (DISP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous problem ROM
  logic [WORD_W-1:0] rom [NUM_Q];
  logic [WORD_W-1:0] rom_q = '0;
  always @(posedge clk) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  // Checker: two-clock verdict pipeline, 00 while check_in is 0
  logic [1:0] chk_pipe = 2'b00;
  logic [1:0] result_q = 2'b00;
  always @(posedge clk) begin
    if (bus.check_in == '0)                        chk_pipe <= RES_IDLE;
    else if (bus.check_in == bus.num_array[23:0])  chk_pipe <= RES_OK;
    else                                           chk_pipe <= RES_NG;
    result_q <= chk_pipe;
  end
  assign bus.result = result_q;

  typedef struct {
    logic [ANS_W-1:0]  answer;
    logic [1:0]        exp_led;
    logic [ADDR_W:0]   exp_score;
    logic [ADDR_W-1:0] exp_q_idx;
    logic              exp_done;
  } round_vec_t;

  round_vec_t vecs [4];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q   = 0;
  logic [1:0] exp_led_prev = RES_IDLE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_e s, input int max_cyc, input string name);
    int k = 0;
    while ((dut.state_q != s) && (k < max_cyc)) begin
      step();
      k++;
    end
    check(name, 64'(dut.state_q), 64'(s));
  endtask

  // One complete answer round driven from the vector table
  task automatic run_round(input int i);
    state_e nxt;
    wait_state(WAIT_ANS, 8, "reach_wait_ans");
    check("led_hold", 64'(bus.led), 64'(exp_led_prev));
    check("q_idx_pre", 64'(bus.q_idx), 64'(exp_q));
    check("num_array", 64'(bus.num_array), 64'(rom[exp_q]));
    bus.submit = 1'b1;
    bus.answer_in = vecs[i].answer;
    step();
    bus.submit = 1'b0;
    bus.answer_in = '0;
    for (int j = 0; j < CHECK_LAT + 1; j++) begin
      check("check_state", 64'(dut.state_q), 64'(CHECK));
      check("check_in_held", 64'(bus.check_in), 64'(vecs[i].answer));
      step();
    end
    check("show_state", 64'(dut.state_q), 64'(SHOW));
    check("led_verdict", 64'(bus.led), 64'(vecs[i].exp_led));
    check("score", 64'(bus.score), 64'(vecs[i].exp_score));
    repeat (DISP_CYC - 1) step();
    check("show_len", 64'(dut.state_q), 64'(SHOW));
    step();
    nxt = vecs[i].exp_done ? DONE : FETCH;
    check("after_show", 64'(dut.state_q), 64'(nxt));
    check("q_idx_post", 64'(bus.q_idx), 64'(vecs[i].exp_q_idx));
    check("done", 64'(bus.done), 64'(vecs[i].exp_done));
    check("busy", 64'(bus.busy), 64'(!vecs[i].exp_done));
    check("check_in_clr", 64'(bus.check_in), 64'(0));
    exp_led_prev = vecs[i].exp_led;
    exp_q = int'(vecs[i].exp_q_idx);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.submit = 1'b0;
    bus.answer_in = '0;
    rom[0] = 36'h5A0000C03;
    rom[1] = 36'h3C1000403;
    //          answer       led     score  q_idx  done
    vecs[0] = '{24'h000C03, RES_OK, 2'd1, 1'b1, 1'b0};  // session 1, problem 0 correct
    vecs[1] = '{24'h000601, RES_NG, 2'd1, 1'b1, 1'b1};  // session 1, problem 1 wrong
    vecs[2] = '{24'h000403, RES_NG, 2'd0, 1'b1, 1'b0};  // session 2, problem 0 wrong
    vecs[3] = '{24'h000403, RES_OK, 2'd1, 1'b1, 1'b1};  // session 2, problem 1 correct

    // Reset state
    #12;
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    check("rst_check_in", 64'(bus.check_in), 64'(0));
    check("rst_num_array", 64'(bus.num_array), 64'(0));
    check("rst_led", 64'(bus.led), 64'(0));
    check("rst_score", 64'(bus.score), 64'(0));
    check("rst_q_idx", 64'(bus.q_idx), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    rst = 1'b0;
    step();

    // Session 1
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("fetch_entry", 64'(dut.state_q), 64'(FETCH));
    check("fetch_rom_addr", 64'(bus.rom_addr), 64'(0));
    check("fetch_busy", 64'(bus.busy), 64'(1));
    step();
    check("fetch_len", 64'(dut.state_q), 64'(FETCH));
    step();
    check("fetch_exit", 64'(dut.state_q), 64'(WAIT_ANS));

    // Zero answer, stray start, and both together are all ignored in WAIT_ANS
    bus.submit = 1'b1;
    bus.answer_in = '0;
    step();
    bus.submit = 1'b0;
    check("zero_sub_state", 64'(dut.state_q), 64'(WAIT_ANS));
    check("zero_sub_chk", 64'(bus.check_in), 64'(0));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_start_state", 64'(dut.state_q), 64'(WAIT_ANS));
    check("busy_start_q", 64'(bus.q_idx), 64'(0));
    bus.start = 1'b1;
    bus.submit = 1'b1;
    step();
    bus.start = 1'b0;
    bus.submit = 1'b0;
    check("both_state", 64'(dut.state_q), 64'(WAIT_ANS));
    check("both_chk", 64'(bus.check_in), 64'(0));

    for (int i = 0; i < 2; i++) run_round(i);

    // Restart from DONE; a simultaneous submit is ignored since DONE is not WAIT_ANS
    bus.start = 1'b1;
    bus.submit = 1'b1;
    bus.answer_in = 24'h000C03;
    step();
    bus.start = 1'b0;
    bus.submit = 1'b0;
    bus.answer_in = '0;
    check("restart_state", 64'(dut.state_q), 64'(FETCH));
    check("restart_score", 64'(bus.score), 64'(0));
    check("restart_q_idx", 64'(bus.q_idx), 64'(0));
    check("restart_rom_addr", 64'(bus.rom_addr), 64'(0));
    check("restart_led", 64'(bus.led), 64'(0));
    check("restart_chk", 64'(bus.check_in), 64'(0));
    exp_q = 0;
    exp_led_prev = RES_IDLE;

    for (int i = 2; i < 4; i++) run_round(i);

    // Session 3: async reset in the second CHECK clock of problem 1
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_q = 0;
    exp_led_prev = RES_IDLE;
    run_round(0);
    wait_state(WAIT_ANS, 8, "rst_wait_ans");
    bus.submit = 1'b1;
    bus.answer_in = 24'h000601;
    step();
    bus.submit = 1'b0;
    bus.answer_in = '0;
    step();
    check("pre_rst_state", 64'(dut.state_q), 64'(CHECK));
    #2;
    rst = 1'b1;
    #1;
    check("arst_check_in", 64'(bus.check_in), 64'(0));
    check("arst_led", 64'(bus.led), 64'(0));
    check("arst_score", 64'(bus.score), 64'(0));
    check("arst_q_idx", 64'(bus.q_idx), 64'(0));
    check("arst_state", 64'(dut.state_q), 64'(IDLE));
    check("arst_busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    check("post_rst_idle", 64'(dut.state_q), 64'(IDLE));

`ifdef FACTOR_TIMEOUT_EN
    // Answer window expires with no submit
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_state(WAIT_ANS, 8, "to_wait_ans");
    repeat (TIMEOUT_CYC - 1) step();
    check("to_last_clk", 64'(dut.state_q), 64'(WAIT_ANS));
    step();
    check("to_show", 64'(dut.state_q), 64'(SHOW));
    check("to_led", 64'(bus.led), 64'(RES_NG));
    check("to_score", 64'(bus.score), 64'(0));
    check("to_chk", 64'(bus.check_in), 64'(0));
    repeat (DISP_CYC) step();
    check("to_next", 64'(dut.state_q), 64'(FETCH));
    check("to_q_idx", 64'(bus.q_idx), 64'(1));
    // Submit on the expiry clock wins over the timeout
    wait_state(WAIT_ANS, 8, "to2_wait_ans");
    repeat (TIMEOUT_CYC - 1) step();
    bus.submit = 1'b1;
    bus.answer_in = 24'h000403;
    step();
    bus.submit = 1'b0;
    bus.answer_in = '0;
    check("to2_check", 64'(dut.state_q), 64'(CHECK));
    check("to2_chk_in", 64'(bus.check_in), 64'(24'h000403));
    repeat (CHECK_LAT + 1) step();
    check("to2_show", 64'(dut.state_q), 64'(SHOW));
    check("to2_led", 64'(bus.led), 64'(RES_OK));
    check("to2_score", 64'(bus.score), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
